// File: rtl/l1i_cache_if.sv
// l1i_cache_if: fetch-side and refill-side signals of the L1 instruction cache.
//   cpu_read_enable / cpu_address / flush : fetch request and invalidate pulse from the CPU
//   cpu_instr / cpu_ready                 : instruction word and its valid flag back to IF/ID
//   mmu_read_enable / mmu_address         : word-read refill request towards the MMU
//   mmu_mem_data_width / mmu_mem_signed_read : access qualifiers (word, unsigned)
//   mmu_mem_ready / mmu_data_out          : refill beat accepted / refill data
// Modport slave is the cache's view; modport master is the CPU+MMU environment.
interface l1i_cache_if;
  logic        cpu_read_enable;
  logic [31:0] cpu_address;
  logic [31:0] cpu_instr;
  logic        cpu_ready;
  logic        flush;
  logic        mmu_read_enable;
  logic [31:0] mmu_address;
  logic [1:0]  mmu_mem_data_width;
  logic        mmu_mem_signed_read;
  logic        mmu_mem_ready;
  logic [31:0] mmu_data_out;

  modport slave (
    input  cpu_read_enable, cpu_address, flush, mmu_mem_ready, mmu_data_out,
    output cpu_instr, cpu_ready, mmu_read_enable, mmu_address,
           mmu_mem_data_width, mmu_mem_signed_read
  );

  modport master (
    output cpu_read_enable, cpu_address, flush, mmu_mem_ready, mmu_data_out,
    input  cpu_instr, cpu_ready, mmu_read_enable, mmu_address,
           mmu_mem_data_width, mmu_mem_signed_read
  );
endinterface

// File: rtl/l1i_cache.sv
// l1i_cache: direct-mapped, read-only L1 instruction cache.
// Hits are served combinationally in IDLE; a miss refills the whole line from
// the MMU one word at a time (words 0..N-1), then the fetch hits in IDLE.
// While not ready the fetch path sees a NOP (addi x0,x0,0).
// Ports:
//   clk      : clock
//   reset_n  : asynchronous, active-low reset
//   bus      : l1i_cache_if.slave (CPU fetch side + MMU refill side)
//   hit_count, miss_count : statistics, present only with L1I_STATS_EN defined
// Optional feature macro: L1I_STATS_EN (adds hit/miss counters and ports).
module l1i_cache #(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  l1i_cache_if.slave  bus
`ifdef L1I_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFF - IDX - 2;

  localparam logic [31:0]    NOP            = 32'h0000_0013;
  localparam logic [1:0]     MMU_WIDTH_WORD = 2'b10;
  localparam logic [OFF-1:0] LAST_BEAT      = OFF'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES][WORDS_PER_LINE];
  logic [OFF-1:0]       counter;
  logic [TAG_W-1:0]     fill_tag;
  logic [IDX-1:0]       fill_index;
  logic                 flush_pending;

  logic [OFF-1:0]   word;
  logic [IDX-1:0]   index;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             miss;
  logic             beat;
  logic             unused_addr_bits;

  assign word  = bus.cpu_address[OFF+1:2];
  assign index = bus.cpu_address[OFF+IDX+1:OFF+2];
  assign tag   = bus.cpu_address[31:OFF+IDX+2];
  assign unused_addr_bits = ^bus.cpu_address[1:0];

  // A flush in IDLE wipes the lines on this edge, so it can never be served as a hit;
  // a request seen together with a flush is therefore treated as a miss.
  assign hit  = (state == IDLE) && bus.cpu_read_enable && !bus.flush &&
                valid[index] && (tags[index] == tag);
  assign miss = (state == IDLE) && bus.cpu_read_enable && !hit;
  assign beat = (state == REFILL) && bus.mmu_mem_ready;

  assign bus.cpu_ready           = hit;
  assign bus.cpu_instr           = hit ? data[index][word] : NOP;
  assign bus.mmu_read_enable     = (state == REFILL);
  // line base + 4*counter, held while the MMU stalls because counter only moves on a beat
  assign bus.mmu_address         = (state == REFILL) ? {fill_tag, fill_index, counter, 2'b00} : 32'h0;
  assign bus.mmu_mem_data_width  = MMU_WIDTH_WORD;
  assign bus.mmu_mem_signed_read = 1'b0;

  // Control state: FSM, valid bits, beat counter, flush tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      valid         <= '0;
      counter       <= '0;
      flush_pending <= 1'b0;
      fill_tag      <= '0;
      fill_index    <= '0;
`ifdef L1I_STATS_EN
      hit_count     <= '0;
      miss_count    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush)
            valid <= '0;
          if (miss) begin
            fill_tag   <= tag;
            fill_index <= index;
            counter    <= '0;
            // old contents of this line are about to be overwritten
            valid[index] <= 1'b0;
            state      <= REFILL;
          end
`ifdef L1I_STATS_EN
          if (hit)
            hit_count <= hit_count + 32'd1;
          if (miss)
            miss_count <= miss_count + 32'd1;
`endif
        end
        REFILL: begin
          if (bus.flush) begin
            valid         <= '0;
            flush_pending <= 1'b1;
          end
          if (bus.mmu_mem_ready) begin
            counter <= counter + 1'b1;
            if (counter == LAST_BEAT) begin
              // a flush seen at any point of this refill (including this edge) leaves the line invalid
              if (!flush_pending && !bus.flush)
                valid[fill_index] <= 1'b1;
              flush_pending <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage: tag and data arrays, not reset (guarded by valid)
  always_ff @(posedge clk) begin
    if (beat) begin
      data[fill_index][counter] <= bus.mmu_data_out;
      if (counter == LAST_BEAT)
        tags[fill_index] <= fill_tag;
    end
  end

endmodule
